usb_buffer_arbiter: RTL and testbench
=====================================

Name: usb_buffer_arbiter

Overview:
- Owns the single-port USB packet buffer RAM (32-bit words) and shares it between the USB receiver write stream and CPU load/store accesses.
- Tracks buffer ownership between receiver and CPU. Raises the external interrupt when a packet is complete, and tells the receiver to ignore new packets until the CPU releases the buffer.
- Sits between the usb receiver, the packet buffer RAM and the core's memory-mapped bus.

Parameters:
- USB_PACKET_BUFFER_SIZE, 1024: buffer size in bytes.
- ADDRESS_WIDTH, $clog2(USB_PACKET_BUFFER_SIZE / 4): word address width (8 at default).

Ports:
- clock48  input  1  48 MHz system clock
- reset  input  1  asynchronous, active-high reset
- usb_write  input  1  receiver writes a word this cycle
- usb_address  input  ADDRESS_WIDTH  receiver word address
- usb_write_value  input  32  receiver word data
- usb_packet_ready  input  1  receiver level; high = packet complete
- usb_busy  output  1  buffer owned by CPU; receiver must ignore incoming packets
- cpu_request  input  1  CPU access request; held until cpu_ready
- cpu_write  input  1  1 = store, 0 = load
- cpu_address  input  ADDRESS_WIDTH  CPU word address
- cpu_write_value  input  32  store data
- cpu_read_value  output  32  load data; valid while cpu_ready is high
- cpu_ready  output  1  one-cycle completion pulse
- cpu_release  input  1  one-cycle pulse; CPU returns the buffer to the receiver
- interrupt  output  1  drives mip_meip
- ram_address  output  ADDRESS_WIDTH  RAM address
- ram_write  output  1  RAM write enable
- ram_write_value  output  32  RAM write data
- ram_read_value  input  32  RAM read data, one cycle after address (synchronous RAM)

Behaviour:
- Reset (async) values:
  - ownership = FREE, access = A_IDLE.
  - usb_busy, interrupt, cpu_ready, ram_write = 0.
  - cpu_read_value = 0, ram_address = 0.
- Ownership FSM:
  - FREE: usb_busy = 0, interrupt = 0.
    - usb_write seen -> FILLING.
    - Rising edge of usb_packet_ready -> CPU_OWNED; this applies from FREE or FILLING.
  - FILLING: usb_busy = 0, interrupt = 0.
    - Rising edge of usb_packet_ready -> CPU_OWNED.
  - CPU_OWNED: usb_busy = 1, interrupt = 1.
    - cpu_release -> FREE on the next edge.
  - Edge detect uses a registered copy of usb_packet_ready. The rising edge is seen one cycle after the input rises.
  - cpu_release outside CPU_OWNED: ignored.
  - Packet-ready edge and cpu_release in the same cycle while CPU_OWNED: release wins -> FREE. The edge is counted as a dropped packet.
- Write protection:
  - usb_write while CPU_OWNED is suppressed: ram_write stays 0 and the event is a drop.
  - A packet-ready edge while CPU_OWNED is also a drop.
- Arbitration (combinational RAM muxing):
  - An unsuppressed usb_write always wins. ram_address = usb_address, ram_write = 1, ram_write_value = usb_write_value. The receiver is never stalled.
  - CPU grant: access = A_IDLE, cpu_request = 1, and no winning usb_write that cycle. ram_address = cpu_address, ram_write = cpu_write.
- Access FSM:
  - A_IDLE: on grant -> A_WAIT.
  - A_WAIT: cpu_ready = 1 for exactly one cycle. For loads, cpu_read_value = ram_read_value, registered into a holding register that is held until the next load. Then -> A_IDLE.
  - Latency from grant to cpu_ready: 1 cycle. Minimum request-to-ready with no contention: 1 cycle.
  - cpu_request still high in the cycle after ready is a new request. The CPU drops it in the ready cycle.
  - CPU access is allowed in every ownership state.
- Back-to-back USB writes starve the CPU for their duration. The receiver writes at most once per 32 bit-times, so starvation is bounded.
- Address arithmetic is word-granular. No wrap or bounds handling here: addresses are ADDRESS_WIDTH bits and wrap naturally.

Optional Feature:
USB_DROP_COUNT_EN:
- Defined:
  - Adds output port dropped_count [7:0].
  - The counter increments once per drop event: a suppressed write cycle, or a packet-ready edge while CPU_OWNED. A suppressed write and a packet-ready edge in the same cycle count once.
  - Saturates at 255.
  - Clears to 0 on reset and on an accepted cpu_release; the clear has priority over a same-cycle increment.
- Not defined: no port and no counter; drops are silently discarded.

Test Plan:
- After reset, assert nothing -> interrupt = 0, usb_busy = 0, cpu_ready = 0, ram_write = 0.
- USB writes words 0..3 = 0x11111111..0x44444444, then usb_packet_ready rises -> FILLING, then CPU_OWNED two cycles after the rise. interrupt = 1, usb_busy = 1. CPU loads at address 2 -> cpu_ready one cycle after grant with cpu_read_value = 0x33333333.
- usb_write to address 5 and CPU store to address 9 in the same cycle -> ram takes USB address 5 first. CPU is granted the next cycle and cpu_ready follows one cycle later (2 cycles total).
- In CPU_OWNED, usb_write 0xDEADBEEF to address 0 -> ram_write stays 0. A later CPU load at address 0 returns 0x11111111. With USB_DROP_COUNT_EN, dropped_count = 1.
- Pulse cpu_release in the same cycle as a usb_packet_ready edge -> state FREE, interrupt = 0 next cycle. With USB_DROP_COUNT_EN, dropped_count = 0 because the clear wins.
- Assert reset during A_WAIT with CPU_OWNED -> cpu_ready = 0 and interrupt = 0 immediately, without waiting for a clock edge. After release, a fresh CPU load completes normally.

Source files
------------

// File: rtl/usb_buffer_arbiter.sv
// Shares the single-port USB packet buffer RAM between the receiver write stream and CPU loads/stores,
// and tracks buffer ownership. Optional drop counter enabled by defining USB_DROP_COUNT_EN.
//
// ownership state | meaning
// S_FREE          | buffer idle, receiver may start a packet
// S_FILLING       | receiver has written at least one word of the current packet
// S_CPU_OWNED     | packet complete, CPU owns buffer, receiver writes suppressed
//
// access state    | meaning
// A_IDLE          | no CPU access outstanding
// A_WAIT          | RAM read/write issued last cycle, cpu_ready asserted
module usb_buffer_arbiter #(
    parameter int USB_PACKET_BUFFER_SIZE = 1024,
    parameter int ADDRESS_WIDTH          = $clog2(USB_PACKET_BUFFER_SIZE / 4)
) (
    input  logic                     clock48,
    input  logic                     reset,
    input  logic                     usb_write,
    input  logic [ADDRESS_WIDTH-1:0] usb_address,
    input  logic [31:0]              usb_write_value,
    input  logic                     usb_packet_ready,
    output logic                     usb_busy,
    input  logic                     cpu_request,
    input  logic                     cpu_write,
    input  logic [ADDRESS_WIDTH-1:0] cpu_address,
    input  logic [31:0]              cpu_write_value,
    output logic [31:0]              cpu_read_value,
    output logic                     cpu_ready,
    input  logic                     cpu_release,
    output logic                     interrupt,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic                     ram_write,
    output logic [31:0]              ram_write_value,
`ifdef USB_DROP_COUNT_EN
    output logic [7:0]               dropped_count,
`endif
    input  logic [31:0]              ram_read_value
);

    localparam logic [1:0] S_FREE      = 2'd0;
    localparam logic [1:0] S_FILLING   = 2'd1;
    localparam logic [1:0] S_CPU_OWNED = 2'd2;

    localparam logic A_IDLE = 1'b0;
    localparam logic A_WAIT = 1'b1;

    logic [1:0]  r_own;
    logic        r_acc;
    logic        r_load;
    logic        r_pr_q1;
    logic        r_pr_q2;
    logic [31:0] r_rd_hold;

    logic w_owned;
    logic w_pr_edge;
    logic w_usb_win;
    logic w_grant;

    assign w_owned   = (r_own == S_CPU_OWNED);
    // Edge is taken between two registered copies, so it is seen one cycle after the input rises.
    assign w_pr_edge = r_pr_q1 & ~r_pr_q2;
    assign w_usb_win = usb_write & ~w_owned;
    assign w_grant   = (r_acc == A_IDLE) & cpu_request & ~w_usb_win;

    assign usb_busy       = w_owned;
    assign interrupt      = w_owned;
    assign cpu_ready      = (r_acc == A_WAIT);
    assign cpu_read_value = (cpu_ready & r_load) ? ram_read_value : r_rd_hold;

    always_comb begin
        ram_address     = '0;
        ram_write       = 1'b0;
        ram_write_value = 32'd0;
        if (w_usb_win) begin
            ram_address     = usb_address;
            ram_write       = 1'b1;
            ram_write_value = usb_write_value;
        end else if (w_grant) begin
            ram_address     = cpu_address;
            ram_write       = cpu_write;
            ram_write_value = cpu_write_value;
        end
    end

    always_ff @(posedge clock48 or posedge reset) begin
        if (reset) begin
            r_own   <= S_FREE;
            r_pr_q1 <= 1'b0;
            r_pr_q2 <= 1'b0;
        end else begin
            r_pr_q1 <= usb_packet_ready;
            r_pr_q2 <= r_pr_q1;
            case (r_own)
                S_FREE: begin
                    if (w_pr_edge)
                        r_own <= S_CPU_OWNED;
                    else if (usb_write)
                        r_own <= S_FILLING;
                end
                S_FILLING: begin
                    if (w_pr_edge)
                        r_own <= S_CPU_OWNED;
                end
                S_CPU_OWNED: begin
                    if (cpu_release)
                        r_own <= S_FREE;
                end
                default: r_own <= S_FREE;
            endcase
        end
    end

    always_ff @(posedge clock48 or posedge reset) begin
        if (reset) begin
            r_acc     <= A_IDLE;
            r_load    <= 1'b0;
            r_rd_hold <= 32'd0;
        end else begin
            case (r_acc)
                A_IDLE: begin
                    if (w_grant) begin
                        r_acc  <= A_WAIT;
                        r_load <= ~cpu_write;
                    end
                end
                default: begin
                    r_acc <= A_IDLE;
                    if (r_load)
                        r_rd_hold <= ram_read_value;
                end
            endcase
        end
    end

`ifdef USB_DROP_COUNT_EN
    logic       w_drop;
    logic [7:0] r_drop_cnt;

    // A suppressed write and a ready edge in the same cycle are one drop event.
    assign w_drop        = w_owned & (usb_write | w_pr_edge);
    assign dropped_count = r_drop_cnt;

    always_ff @(posedge clock48 or posedge reset) begin
        if (reset)
            r_drop_cnt <= 8'd0;
        else if (w_owned & cpu_release)
            r_drop_cnt <= 8'd0;
        else if (w_drop && r_drop_cnt != 8'hFF)
            r_drop_cnt <= r_drop_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// Directed bench for usb_buffer_arbiter: abstract ownership/access model checked every cycle plus literal pins.
// Drop-count checks are active when USB_DROP_COUNT_EN is defined.
module tb_usb_buffer_arbiter;

    logic        clock48;
    logic        reset;
    logic        usb_write;
    logic [7:0]  usb_address;
    logic [31:0] usb_write_value;
    logic        usb_packet_ready;
    logic        usb_busy;
    logic        cpu_request;
    logic        cpu_write;
    logic [7:0]  cpu_address;
    logic [31:0] cpu_write_value;
    logic [31:0] cpu_read_value;
    logic        cpu_ready;
    logic        cpu_release;
    logic        interrupt;
    logic [7:0]  ram_address;
    logic        ram_write;
    logic [31:0] ram_write_value;
    logic [31:0] ram_read_value;
`ifdef USB_DROP_COUNT_EN
    logic [7:0]  dropped_count;
`endif

    int vectors = 0;
    int errors  = 0;

    usb_buffer_arbiter dut (
        .clock48          (clock48),
        .reset            (reset),
        .usb_write        (usb_write),
        .usb_address      (usb_address),
        .usb_write_value  (usb_write_value),
        .usb_packet_ready (usb_packet_ready),
        .usb_busy         (usb_busy),
        .cpu_request      (cpu_request),
        .cpu_write        (cpu_write),
        .cpu_address      (cpu_address),
        .cpu_write_value  (cpu_write_value),
        .cpu_read_value   (cpu_read_value),
        .cpu_ready        (cpu_ready),
        .cpu_release      (cpu_release),
        .interrupt        (interrupt),
        .ram_address      (ram_address),
        .ram_write        (ram_write),
        .ram_write_value  (ram_write_value),
`ifdef USB_DROP_COUNT_EN
        .dropped_count    (dropped_count),
`endif
        .ram_read_value   (ram_read_value)
    );

    initial clock48 = 1'b0;
    always #10 clock48 = ~clock48;

    // Synchronous read-first packet RAM.
    logic [31:0] ram_mem [256];
    initial for (int i = 0; i < 256; i++) ram_mem[i] = 32'd0;
    always @(posedge clock48) begin
        if (ram_write) ram_mem[ram_address] <= ram_write_value;
        ram_read_value <= ram_mem[ram_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: buffer contents, ownership flag, pending CPU access, drop tally.
    logic [31:0] m_mem [256];
    initial for (int i = 0; i < 256; i++) m_mem[i] = 32'd0;
    bit          m_owned, m_pr_h1, m_pr_h2, m_wait, m_wait_load;
    logic [31:0] m_pend, m_hold;
    int          m_cnt;

    always @(posedge clock48 or posedge reset) begin
        bit edge_now, usb_ok, grant, drop;
        if (reset) begin
            m_owned = 0; m_pr_h1 = 0; m_pr_h2 = 0; m_wait = 0; m_wait_load = 0;
            m_pend = 32'd0; m_hold = 32'd0; m_cnt = 0;
        end else begin
            edge_now = m_pr_h1 && !m_pr_h2;
            usb_ok   = usb_write && !m_owned;
            grant    = !m_wait && cpu_request && !usb_ok;
            drop     = m_owned && (usb_write || edge_now);
            if (m_owned && cpu_release) m_cnt = 0;
            else if (drop && m_cnt < 255) m_cnt++;
            if (m_owned) m_owned = !cpu_release;
            else         m_owned = edge_now;
            if (usb_ok) m_mem[usb_address] = usb_write_value;
            else if (grant && cpu_write) m_mem[cpu_address] = cpu_write_value;
            if (m_wait) begin
                if (m_wait_load) m_hold = m_pend;
                m_wait = 0;
            end else if (grant) begin
                m_wait = 1;
                m_wait_load = !cpu_write;
                m_pend = m_mem[cpu_address];
            end
            m_pr_h2 = m_pr_h1;
            m_pr_h1 = usb_packet_ready;
        end
    end

    always @(negedge clock48) begin
        bit usb_ok, grant;
        usb_ok = usb_write && !m_owned;
        grant  = !m_wait && cpu_request && !usb_ok;
        chk("m_interrupt", interrupt, m_owned);
        chk("m_usb_busy", usb_busy, m_owned);
        chk("m_cpu_ready", cpu_ready, m_wait);
        chk("m_ram_write", ram_write, usb_ok || (grant && cpu_write));
        if (usb_ok) begin
            chk("m_ram_addr_usb", ram_address, usb_address);
            chk("m_ram_wdata_usb", ram_write_value, usb_write_value);
        end else if (grant) begin
            chk("m_ram_addr_cpu", ram_address, cpu_address);
            if (cpu_write) chk("m_ram_wdata_cpu", ram_write_value, cpu_write_value);
        end
        chk("m_cpu_read_value", cpu_read_value, (m_wait && m_wait_load) ? m_pend : m_hold);
`ifdef USB_DROP_COUNT_EN
        chk("m_dropped_count", dropped_count, m_cnt[7:0]);
`endif
    end

    task automatic step;
        @(posedge clock48);
        #1;
    endtask

    task automatic cpu_op(input logic w, input logic [7:0] a, input logic [31:0] d, output logic [31:0] rv);
        cpu_request = 1'b1; cpu_write = w; cpu_address = a; cpu_write_value = d;
        step;
        cpu_request = 1'b0;
        @(negedge clock48);
        chk("op_ready", cpu_ready, 1'b1);
        rv = cpu_read_value;
        step;
    endtask

    initial begin
        logic [31:0] rv;
        reset = 1'b1; usb_write = 0; usb_address = 0; usb_write_value = 0; usb_packet_ready = 0;
        cpu_request = 0; cpu_write = 0; cpu_address = 0; cpu_write_value = 0; cpu_release = 0;
        repeat (3) step;
        @(negedge clock48);
        chk("rst_interrupt", interrupt, 1'b0);
        chk("rst_usb_busy", usb_busy, 1'b0);
        chk("rst_cpu_ready", cpu_ready, 1'b0);
        chk("rst_ram_write", ram_write, 1'b0);
        chk("rst_ram_address", ram_address, 32'd0);
        chk("rst_cpu_read_value", cpu_read_value, 32'd0);
        step;
        reset = 1'b0;
        step;

        for (int i = 0; i < 4; i++) begin
            usb_write = 1'b1; usb_address = 8'(i); usb_write_value = 32'h11111111 * (i + 1);
            step;
        end
        usb_write = 1'b0;

        // Collision: receiver write wins, CPU store follows one cycle later.
        usb_write = 1'b1; usb_address = 8'd5; usb_write_value = 32'h55555555;
        cpu_request = 1'b1; cpu_write = 1'b1; cpu_address = 8'd9; cpu_write_value = 32'h99999999;
        @(negedge clock48);
        chk("coll_addr_usb", ram_address, 32'd5);
        chk("coll_ready0", cpu_ready, 1'b0);
        step;
        usb_write = 1'b0;
        @(negedge clock48);
        chk("coll_addr_cpu", ram_address, 32'd9);
        chk("coll_wr_cpu", ram_write, 1'b1);
        step;
        cpu_request = 1'b0;
        @(negedge clock48);
        chk("coll_ready2", cpu_ready, 1'b1);
        step;

        usb_packet_ready = 1'b1;
        @(negedge clock48);
        chk("pr_int_rise", interrupt, 1'b0);
        step;
        @(negedge clock48);
        chk("pr_int_edge", interrupt, 1'b0);
        step;
        @(negedge clock48);
        chk("pr_int_owned", interrupt, 1'b1);
        chk("pr_busy_owned", usb_busy, 1'b1);
        step;

        cpu_op(1'b0, 8'd2, 32'd0, rv);
        chk("load2", rv, 32'h33333333);
        cpu_op(1'b0, 8'd9, 32'd0, rv);
        chk("load9", rv, 32'h99999999);

        // Request held through ready becomes a second access.
        cpu_request = 1'b1; cpu_write = 1'b0; cpu_address = 8'd1;
        repeat (3) step;
        cpu_request = 1'b0;
        step;

        usb_write = 1'b1; usb_address = 8'd0; usb_write_value = 32'hDEADBEEF;
        @(negedge clock48);
        chk("supp_ram_write", ram_write, 1'b0);
        step;
        usb_write = 1'b0;
        cpu_op(1'b0, 8'd0, 32'd0, rv);
        chk("supp_load0", rv, 32'h11111111);
`ifdef USB_DROP_COUNT_EN
        chk("supp_dropcnt", dropped_count, 32'd1);
`endif

        // Release coincides with a new packet-ready edge: release wins.
        usb_packet_ready = 1'b0;
        repeat (3) step;
        usb_packet_ready = 1'b1;
        step;
        cpu_release = 1'b1;
        @(negedge clock48);
        chk("rel_int_before", interrupt, 1'b1);
        step;
        cpu_release = 1'b0;
        @(negedge clock48);
        chk("rel_int_after", interrupt, 1'b0);
`ifdef USB_DROP_COUNT_EN
        chk("rel_dropcnt", dropped_count, 32'd0);
`endif
        step;

        usb_packet_ready = 1'b0;
        repeat (2) step;
        usb_packet_ready = 1'b1;
        repeat (3) step;
        cpu_request = 1'b1; cpu_write = 1'b0; cpu_address = 8'd1;
        step;
        cpu_request = 1'b0;
        usb_packet_ready = 1'b0;
        #2;
        chk("arst_ready_pre", cpu_ready, 1'b1);
        chk("arst_int_pre", interrupt, 1'b1);
        reset = 1'b1;
        #1;
        chk("arst_ready", cpu_ready, 1'b0);
        chk("arst_int", interrupt, 1'b0);
        step;
        reset = 1'b0;
        step;
        cpu_release = 1'b1;
        step;
        cpu_release = 1'b0;
        cpu_op(1'b0, 8'd3, 32'd0, rv);
        chk("post_rst_load3", rv, 32'h44444444);
        @(negedge clock48);
        chk("post_rst_int", interrupt, 1'b0);
        repeat (2) step;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
